// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared opmode decode constants and Z-select enum for dsp_mac_slice
//
// Contents:
//   z_sel_e      : post-adder Z operand select (ZERO, P, C, PCIN)
//   OPM_*        : bit positions inside the 5-bit opmode word
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    P    = 2'd1,
    C    = 2'd2,
    PCIN = 2'd3
  } z_sel_e;

  localparam int OPM_W        = 5;
  localparam int OPM_PRE_SUB  = 0;  // pre-adder: 1 = d-b, 0 = d+b
  localparam int OPM_PRE_EN   = 1;  // pre-adder: 1 = use d+/-b, 0 = pass b
  localparam int OPM_Z_LSB    = 2;  // Z select field [3:2]
  localparam int OPM_Z_MSB    = 3;
  localparam int OPM_POST_SUB = 4;  // post-adder: 1 = z - (m + cin)

endpackage

// File: rtl/dsp_mac_slice_pipe_reg.sv
// rtl/dsp_mac_slice_pipe_reg.sv - width-parametrised stage register (module dsp_pipe_reg)
//
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, clears o_q to zero
//   i_en    : load enable
//   i_d     : next value [W]
//   o_q     : registered value [W]
module dsp_pipe_reg #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/dsp_mac_slice.sv
// rtl/dsp_mac_slice.sv - three-stage pre-add / multiply / post-add MAC slice
//
// Optional feature: define DSP_MAC_SAT_EN to saturate p on overflow
// (carry_out forced to 0); otherwise p wraps modulo 2^P_W.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   ce                 : global enable, low freezes every register
//   clr                : synchronous clear of the P stage (p, carry_out, overflow, out_valid)
//   a [A_W], b/d [B_W] : multiplier / pre-adder operands (signed)
//   c, pcin [P_W]      : Z-mux operands (signed)
//   opmode [5], cin    : operation select and post-adder carry in
//   in_valid           : operands qualify this cycle
//   bcout [B_W]        : stage-1 b register
//   m [A_W+B_W+1]      : M register (pre-add result * a)
//   p, pcout [P_W]     : P register (pcout mirrors p)
//   carry_out          : bit P_W of the post-adder result
//   overflow           : sticky, result left the signed P_W range
//   out_valid          : p was loaded on the last enabled edge
module dsp_mac_slice
  import dsp_mac_pkg::*;
#(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int P_W = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   clr,
  input  logic signed [A_W-1:0]  a,
  input  logic signed [B_W-1:0]  b,
  input  logic signed [B_W-1:0]  d,
  input  logic signed [P_W-1:0]  c,
  input  logic signed [P_W-1:0]  pcin,
  input  logic [OPM_W-1:0]       opmode,
  input  logic                   cin,
  input  logic                   in_valid,
  output logic signed [B_W-1:0]  bcout,
  output logic signed [A_W+B_W:0] m,
  output logic signed [P_W-1:0]  p,
  output logic signed [P_W-1:0]  pcout,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   out_valid
);

  localparam int M_W   = A_W + B_W + 1;
  localparam int OP2_W = OPM_POST_SUB - OPM_Z_LSB + 1;
  localparam int S1_W  = A_W + 2 * B_W + 2 * P_W + OPM_W + 2;
  localparam int S2_W  = M_W + 2 * P_W + OP2_W + 2;
  localparam int S3_W  = P_W + 3;

  // Stage 1: operand capture
  logic [S1_W-1:0]        w_s1_d;
  logic [S1_W-1:0]        r_s1;
  logic signed [A_W-1:0]  r_a1;
  logic signed [B_W-1:0]  r_b1;
  logic signed [B_W-1:0]  r_d1;
  logic signed [P_W-1:0]  r_c1;
  logic signed [P_W-1:0]  r_pcin1;
  logic [OPM_W-1:0]       r_op1;
  logic                   r_cin1;
  logic                   r_v1;

  assign w_s1_d = {a, b, d, c, pcin, opmode, cin, in_valid};

  dsp_pipe_reg #(.W(S1_W)) u_stage1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (ce),
    .i_d     (w_s1_d),
    .o_q     (r_s1)
  );

  assign {r_a1, r_b1, r_d1, r_c1, r_pcin1, r_op1, r_cin1, r_v1} = r_s1;

  // Pre-adder, one bit wider than b/d so d+b and d-b never wrap
  logic [B_W:0] w_b1x;
  logic [B_W:0] w_d1x;
  logic [B_W:0] w_pa;

  assign w_b1x = {r_b1[B_W-1], r_b1};
  assign w_d1x = {r_d1[B_W-1], r_d1};
  assign w_pa  = !r_op1[OPM_PRE_EN] ? w_b1x :
                 (r_op1[OPM_PRE_SUB] ? (w_d1x - w_b1x) : (w_d1x + w_b1x));

  // Multiplier: both factors sign-extended to the product width, so the
  // truncated same-width product equals the full signed product.
  logic signed [M_W-1:0] w_pa_m;
  logic signed [M_W-1:0] w_a_m;
  logic signed [M_W-1:0] w_prod;

  assign w_pa_m = {{(M_W-B_W-1){w_pa[B_W]}}, w_pa};
  assign w_a_m  = {{(M_W-A_W){r_a1[A_W-1]}}, r_a1};
  assign w_prod = w_pa_m * w_a_m;

  // Stage 2: M register plus the Z operands / control delayed to line up with m
  logic [S2_W-1:0]                    w_s2_d;
  logic [S2_W-1:0]                    r_s2;
  logic signed [M_W-1:0]              r_m2;
  logic signed [P_W-1:0]              r_c2;
  logic signed [P_W-1:0]              r_pcin2;
  logic [OPM_POST_SUB:OPM_Z_LSB]      r_op2;
  logic                               r_cin2;
  logic                               r_v2;

  assign w_s2_d = {w_prod, r_c1, r_pcin1, r_op1[OPM_POST_SUB:OPM_Z_LSB], r_cin1, r_v1};

  dsp_pipe_reg #(.W(S2_W)) u_stage2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (ce),
    .i_d     (w_s2_d),
    .o_q     (r_s2)
  );

  assign {r_m2, r_c2, r_pcin2, r_op2, r_cin2, r_v2} = r_s2;

  // Z mux; the P input is the live P register so accumulations chain
  // back-to-back without bubbles.
  logic signed [P_W-1:0] r_p;
  logic                  r_carry;
  logic                  r_ovf;
  logic                  r_vout;
  z_sel_e                w_zsel;
  logic [P_W-1:0]        w_z;

  assign w_zsel = z_sel_e'(r_op2[OPM_Z_MSB:OPM_Z_LSB]);

  always_comb begin
    w_z = '0;
    case (w_zsel)
      ZERO:    w_z = '0;
      P:       w_z = r_p;
      C:       w_z = r_c2;
      PCIN:    w_z = r_pcin2;
      default: w_z = '0;
    endcase
  end

  // Post-adder in P_W+1 bits: the exact signed result always fits, so
  // overflow is simply the top two bits disagreeing.
  logic [P_W:0]   w_zx;
  logic [P_W:0]   w_mx;
  logic [P_W:0]   w_cx;
  logic [P_W:0]   w_sum;
  logic           w_ovf;
  logic [P_W-1:0] w_p_load;
  logic           w_co_load;

  assign w_zx  = {w_z[P_W-1], w_z};
  assign w_mx  = {{(P_W+1-M_W){r_m2[M_W-1]}}, r_m2};
  assign w_cx  = {{P_W{1'b0}}, r_cin2};
  assign w_sum = r_op2[OPM_POST_SUB] ? (w_zx - (w_mx + w_cx)) : (w_zx + w_mx + w_cx);
  assign w_ovf = w_sum[P_W] ^ w_sum[P_W-1];

`ifdef DSP_MAC_SAT_EN
  localparam logic [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

  // Sign of the wide result tells which rail was crossed.
  assign w_p_load  = w_ovf ? (w_sum[P_W] ? P_MIN : P_MAX) : w_sum[P_W-1:0];
  assign w_co_load = w_ovf ? 1'b0 : w_sum[P_W];
`else
  assign w_p_load  = w_sum[P_W-1:0];
  assign w_co_load = w_sum[P_W];
`endif

  // Stage 3 next-state: clr wins over a load; without v2 p holds and
  // out_valid drops.
  logic [P_W-1:0] w_p_nxt;
  logic           w_co_nxt;
  logic           w_ov_nxt;
  logic           w_vo_nxt;
  logic [S3_W-1:0] r_s3;

  always_comb begin
    w_p_nxt  = r_p;
    w_co_nxt = r_carry;
    w_ov_nxt = r_ovf;
    w_vo_nxt = 1'b0;
    if (clr) begin
      w_p_nxt  = '0;
      w_co_nxt = 1'b0;
      w_ov_nxt = 1'b0;
    end else if (r_v2) begin
      w_p_nxt  = w_p_load;
      w_co_nxt = w_co_load;
      w_ov_nxt = r_ovf | w_ovf;
      w_vo_nxt = 1'b1;
    end
  end

  dsp_pipe_reg #(.W(S3_W)) u_stage3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (ce),
    .i_d     ({w_p_nxt, w_co_nxt, w_ov_nxt, w_vo_nxt}),
    .o_q     (r_s3)
  );

  assign {r_p, r_carry, r_ovf, r_vout} = r_s3;

  assign bcout     = r_b1;
  assign m         = r_m2;
  assign p         = r_p;
  assign pcout     = r_p;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;
  assign out_valid = r_vout;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// tb/tb_dsp_mac_slice.sv - scoreboard testbench for dsp_mac_slice
module tb_dsp_mac_slice;

  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -PMAX - 1;
`ifdef DSP_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, ce, clr, cin, in_valid;
  logic signed [17:0] a, b, d;
  logic signed [47:0] c, pcin;
  logic [4:0] opmode;
  logic signed [17:0] bcout;
  logic signed [36:0] m;
  logic signed [47:0] p, pcout;
  logic carry_out, overflow, out_valid;

  typedef struct {
    longint p;
    logic   co;
    logic   ov;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint model_p = 0;
  logic   model_ov = 1'b0;
  logic   en_edge;
  longint snap_p;
  logic [57:0] snap_ctl;

  dsp_mac_slice dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .clr       (clr),
    .a         (a),
    .b         (b),
    .d         (d),
    .c         (c),
    .pcin      (pcin),
    .opmode    (opmode),
    .cin       (cin),
    .in_valid  (in_valid),
    .bcout     (bcout),
    .m         (m),
    .p         (p),
    .pcout     (pcout),
    .carry_out (carry_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  task automatic model_push(input longint ia, ib, id, ic, ipc, input logic [4:0] op, input logic icin);
    longint pa, mm, z, r;
    logic [63:0] rv;
    logic signed [47:0] pw;
    logic ov;
    exp_t e;
    if (!op[1])     pa = ib;
    else if (op[0]) pa = id - ib;
    else            pa = id + ib;
    mm = pa * ia;
    case (op[3:2])
      2'd0:    z = 0;
      2'd1:    z = model_p;
      2'd2:    z = ic;
      default: z = ipc;
    endcase
    r  = op[4] ? (z - (mm + (icin ? 1 : 0))) : (z + mm + (icin ? 1 : 0));
    rv = r;
    ov = (r > PMAX) || (r < PMIN);
    if (SAT && ov) begin
      e.p  = (r > PMAX) ? PMAX : PMIN;
      e.co = 1'b0;
    end else begin
      pw   = rv[47:0];
      e.p  = pw;
      e.co = rv[48];
    end
    e.ov     = model_ov | ov;
    model_p  = e.p;
    model_ov = e.ov;
    q.push_back(e);
  endtask

  // Monitor: one new result per enabled edge that leaves out_valid high.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) en_edge <= 1'b0;
    else        en_edge <= ce;

  always @(negedge clk) begin
    if (rst_n && en_edge && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got p=%0h expected no result", p);
      end else begin
        mon_e = q.pop_front();
        chk("sb_p",         64'(p),     mon_e.p);
        chk("sb_pcout",     64'(pcout), mon_e.p);
        chk("sb_carry_out", carry_out,  mon_e.co);
        chk("sb_overflow",  overflow,   mon_e.ov);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic signed [17:0] ia, ib, id, input logic signed [47:0] ic, ipc,
                       input logic [4:0] iop, input logic icin, input bit push);
    a = ia; b = ib; d = id; c = ic; pcin = ipc; opmode = iop; cin = icin; in_valid = 1'b1;
    if (push) model_push(ia, ib, id, ic, ipc, iop, icin);
    step();
    in_valid = 1'b0;
  endtask

  task automatic rand_issue();
    issue(18'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
          48'({$urandom, $urandom}), 5'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && k < 30) begin
      step();
      k++;
    end
    chk(name, q.size(), 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_p  = 0;
    model_ov = 1'b0;
    chk("clr_p", 64'(p), 0);
    chk("clr_overflow", overflow, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_p"},         64'(p),     0);
    chk({tag, "_pcout"},     64'(pcout), 0);
    chk({tag, "_m"},         64'(m),     0);
    chk({tag, "_bcout"},     64'(bcout), 0);
    chk({tag, "_out_valid"}, out_valid,  0);
    chk({tag, "_overflow"},  overflow,   0);
    chk({tag, "_carry_out"}, carry_out,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ce = 1'b1; clr = 1'b0; in_valid = 1'b0; cin = 1'b0;
    a = '0; b = '0; d = '0; c = '0; pcin = '0; opmode = '0;
    repeat (2) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Test 1: d-b pre-add, Z=0, latency 3
    issue(3, 4, 5, 0, 0, 5'b00011, 1'b0, 1'b1);
    chk("t1_lat1", out_valid, 0);
    step();
    chk("t1_lat2", out_valid, 0);
    step();
    chk("t1_lat3", out_valid, 1);
    chk("t1_p", 64'(p), 3);
    drain("t1_drain");

    // Test 2: back-to-back accumulation from p=0
    do_clr();
    repeat (4) issue(2, 10, 0, 0, 0, 5'b00100, 1'b0, 1'b1);
    chk("t2_p40", 64'(p), 40);
    step();
    chk("t2_p60", 64'(p), 60);
    step();
    chk("t2_p80", 64'(p), 80);
    chk("t2_valid", out_valid, 1);
    drain("t2_drain");

    // Test 3: subtract with Z=C and carry in
    issue(-1, 1, 0, 100, 0, 5'b11000, 1'b1, 1'b1);
    chk("t3_bcout", 64'(bcout), 1);
    step();
    chk("t3_m", 64'(m), -1);
    drain("t3_drain");
    chk("t3_p", 64'(p), 100);

    // Test 4: overflow at the positive rail
    do_clr();
    issue(0, 0, 0, 48'h7FFF_FFFF_FFFF, 0, 5'b01000, 1'b0, 1'b1);
    issue(1, 1, 0, 0, 0, 5'b00100, 1'b0, 1'b1);
    drain("t4_drain");
    chk("t4_p", 64'(p), SAT ? PMAX : PMIN);
    chk("t4_overflow", overflow, 1);

    // clr beats a simultaneous stage-3 load
    issue(5, 5, 0, 0, 0, 5'b00000, 1'b0, 1'b0);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_p  = 0;
    model_ov = 1'b0;
    chk("clrpri_out_valid", out_valid, 0);
    chk("clrpri_p", 64'(p), 0);
    chk("clrpri_overflow", overflow, 0);
    chk("clrpri_carry_out", carry_out, 0);

    // Test 5: ce low for 5 cycles mid-stream, with garbage and clr ignored
    repeat (3) rand_issue();
    ce = 1'b0; clr = 1'b1; in_valid = 1'b1;
    a = 18'($urandom); b = 18'($urandom); opmode = 5'($urandom);
    snap_p   = 64'(p);
    snap_ctl = {m, bcout, carry_out, overflow, out_valid};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_freeze_p", 64'(p), snap_p);
      chk("t5_freeze_ctl", 64'({m, bcout, carry_out, overflow, out_valid}), 64'(snap_ctl));
    end
    ce = 1'b1; clr = 1'b0;
    repeat (3) rand_issue();
    drain("t5_drain");

    // Randomised stream with enable gaps and idle cycles
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ce = 1'($urandom);
        in_valid = 1'b0;
        step();
        ce = 1'b1;
      end
      rand_issue();
    end
    drain("rand_drain");

    // Test 6: async reset with two operands in flight
    repeat (2) rand_issue();
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("t6_reset");
    q.delete();
    model_p  = 0;
    model_ov = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (5) step();
    chk("t6_quiet", out_valid, 0);
    issue(7, 3, 0, 0, 0, 5'b00000, 1'b0, 1'b1);
    chk("t6_lat1", out_valid, 0);
    step();
    chk("t6_lat2", out_valid, 0);
    step();
    chk("t6_lat3", out_valid, 1);
    chk("t6_p", 64'(p), 21);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
